pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 core. It drives the enable, stall and flush controls of the IF/ID latch, the ID/EX latch, the EX/MEM and MEM/WB enables, and the PC enable. It resolves load-use hazards, EX-stage redirects and multi-cycle instruction/data memory waits, and contains a wait watchdog and performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// It handles load-use, redirect and memory-wait hazards, a wait watchdog and performance counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, IWAIT, DWAIT, ERR} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic [7:0] r_wait_cnt, w_cnt_eff, w_cnt_next;
  logic r_last_d, w_load_use, w_dw, w_iw, w_frz, w_timeout;
  assign w_load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign w_dw = mem_req & ~dmem_ready;
  // an instruction wait only counts when nothing of higher priority owns the cycle
  assign w_iw = ~imem_ready & ~w_dw & ~ex_redirect & ~w_load_use;
  assign w_frz = rst | (r_state == ERR) | w_dw;
  assign error = (r_state == ERR);
  always_comb begin
    pc_en       = ~w_frz & (ex_redirect | ~(w_load_use | ~imem_ready));
    if_id_en    = ~w_frz;
    if_id_stall = ~w_frz & ~ex_redirect & w_load_use;
    if_id_flush = ~w_frz & (ex_redirect | (~w_load_use & ~imem_ready));
    id_ex_en    = ~w_frz;
    id_ex_flush = ~w_frz & (ex_redirect | w_load_use);
    ex_mem_en   = ~w_frz;
    mem_wb_en   = ~w_frz;
  end
  // a switch between instruction and data waits restarts the count
  always_comb begin
    w_cnt_eff  = (w_dw == r_last_d) ? r_wait_cnt : 8'd0;
    w_timeout  = (w_dw | w_iw) & (w_cnt_eff == LAST);
    w_cnt_next = (w_dw | w_iw) ? w_cnt_eff + 8'd1 : 8'd0;
    w_next     = (r_state == ERR) | w_timeout ? ERR :
                 w_dw ? DWAIT :
                 (~imem_ready & ~ex_redirect) ? IWAIT : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
      r_last_d   <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != ERR) begin
        r_wait_cnt <= w_cnt_next;
        if (w_dw | w_iw) r_last_d <= w_dw;
        if (~pc_en & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
        if (ex_redirect & ~w_dw & ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard priority, waits, watchdog, counters and reset.
module tb_pipeline_hazard_ctrl;
  localparam logic [7:0] RUN_C = 8'b1100_1011;
  localparam logic [7:0] LU_C  = 8'b0110_1111;
  localparam logic [7:0] RD_C  = 8'b1101_1111;
  localparam logic [7:0] IW_C  = 8'b0101_1011;
  localparam logic [7:0] OFF_C = 8'b0000_0000;
  logic clk = 1'b0, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, imem_ready, mem_req, dmem_ready;
  logic pc_en, if_id_en, if_id_stall, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, error;
  logic [31:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;
  int n_chk = 0, n_err = 0;
  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .error(error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  assign ctl = {pc_en, if_id_en, if_id_stall, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_req} = '0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctl", 32'(ctl), 32'(OFF_C));
    chk("rst_err", 32'(error), 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk) chk("run", 32'(ctl), 32'(RUN_C));
    nxt();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    @(negedge clk) chk("lu", 32'(ctl), 32'(LU_C));
    nxt();
    ex_mem_read = 1'b0;
    @(negedge clk) chk("lu_done", 32'(ctl), 32'(RUN_C));
    chk("lu_stall", stall_cnt, 1);
    nxt();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge clk) chk("x0", 32'(ctl), 32'(RUN_C));
    nxt();
    ex_rd = 5'd7; id_rs1 = 5'd7; ex_redirect = 1'b1;
    @(negedge clk) chk("redir_lu", 32'(ctl), 32'(RD_C));
    nxt();
    idle();
    @(negedge clk) chk("redir_flush", flush_cnt, 1);
    chk("redir_stall", stall_cnt, 1);
    nxt();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) chk($sformatf("dw%0d", i), 32'(ctl), 32'(OFF_C));
      nxt();
    end
    dmem_ready = 1'b1;
    @(negedge clk) chk("dw_rdy", 32'(ctl), 32'(RD_C));
    chk("dw_stall", stall_cnt, 4);
    chk("dw_flush", flush_cnt, 1);
    nxt();
    idle();
    @(negedge clk) chk("dw_flush2", flush_cnt, 2);
    chk("dw_err", 32'(error), 0);
    nxt();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) chk($sformatf("iw%0d", i), 32'(ctl), 32'(IW_C));
      nxt();
    end
    imem_ready = 1'b1;
    @(negedge clk) chk("iw_done", 32'(ctl), 32'(RUN_C));
    chk("iw_stall", stall_cnt, 6);
    nxt();
    imem_ready = 1'b0;
    @(negedge clk) chk("iw_pre_rst", 32'(ctl), 32'(IW_C));
    nxt();
    rst = 1'b1;
    @(negedge clk) chk("iw_rst_ctl", 32'(ctl), 32'(OFF_C));
    chk("iw_rst_stall", stall_cnt, 0);
    chk("iw_rst_flush", flush_cnt, 0);
    nxt();
    rst = 1'b0; imem_ready = 1'b1;
    @(negedge clk) chk("iw_rst_run", 32'(ctl), 32'(RUN_C));
    nxt();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) chk($sformatf("to_ctl%0d", i), 32'(ctl), 32'(OFF_C));
      chk($sformatf("to_err%0d", i), 32'(error), 0);
      nxt();
    end
    mem_req = 1'b0; dmem_ready = 1'b1;
    @(negedge clk) chk("err_set", 32'(error), 1);
    chk("err_ctl", 32'(ctl), 32'(OFF_C));
    chk("err_stall", stall_cnt, 4);
    nxt();
    @(negedge clk) chk("err_hold_ctl", 32'(ctl), 32'(OFF_C));
    chk("err_hold_stall", stall_cnt, 4);
    chk("err_hold", 32'(error), 1);
    nxt();
    rst = 1'b1;
    @(negedge clk) chk("err_rst_err", 32'(error), 0);
    chk("err_rst_stall", stall_cnt, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk) chk("err_rst_run", 32'(ctl), 32'(RUN_C));
    nxt();
    mem_req = 1'b1; dmem_ready = 1'b0;
    nxt();
    nxt();
    mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) chk($sformatf("sw_ctl%0d", i), 32'(ctl), 32'(IW_C));
      nxt();
    end
    @(negedge clk) chk("sw_no_err", 32'(error), 0);
    nxt();
    @(negedge clk) chk("sw_iw_to", 32'(error), 1);
    idle();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
